// File: rtl/seq_word_serializer_if.sv
// Word-in / bit-out bus for seq_word_serializer: parallel push handshake,
// serial stream outputs and FIFO occupancy.
interface seq_word_serializer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    logic [W-1:0]            in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    data_stream;
    logic                    bit_valid;
    logic                    word_start;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output in_data, in_valid,
        input  in_ready, data_stream, bit_valid, word_start, fifo_count
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data_stream, bit_valid, word_start, fifo_count
    );
endinterface

// File: rtl/seq_word_serializer.sv
// FIFO-buffered MSB-first word serializer with registered stream outputs.
// Define SER_PARITY_EN to append one even-parity bit after every word.
module seq_word_serializer #(
    parameter int   W        = 8,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_word_serializer_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(W + 1);
`ifdef SER_PARITY_EN
    localparam int LAST = W;
`else
    localparam int LAST = W - 1;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [W-1:0]    shift_reg;
    logic [CW-1:0]   bit_cnt_reg;
`ifdef SER_PARITY_EN
    logic            parity_reg;
`endif
    logic            data_stream_reg, data_stream_next;
    logic            bit_valid_reg, bit_valid_next;
    logic            word_start_reg, word_start_next;
    logic            push, pop, last_bit, fifo_empty;
    logic [W-1:0]    head_word;

    assign bus.in_ready = (count_reg < CNTW'(DEPTH)) && reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_empty   = (count_reg == '0);
    assign last_bit     = (state_reg == SHIFT) && (bit_cnt_reg == CW'(LAST));
    // Pop on leaving IDLE or on the final bit period so words run back to back.
    assign pop          = !fifo_empty && ((state_reg == IDLE) || last_bit);
    assign head_word    = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_reg] <= bus.in_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = SHIFT;
            SHIFT:   if (last_bit && !pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
`ifdef SER_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (pop) begin
            shift_reg   <= head_word;
            bit_cnt_reg <= '0;
`ifdef SER_PARITY_EN
            parity_reg  <= ^head_word;
`endif
        end else if (state_reg == SHIFT && !last_bit) begin
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
        end
    end

    // Outputs are computed one period early and registered, so the stream
    // presents the bit that the shift register will hold after this edge.
    always_comb begin
        data_stream_next = IDLE_BIT;
        bit_valid_next   = 1'b0;
        word_start_next  = 1'b0;
        if (pop) begin
            data_stream_next = head_word[W-1];
            bit_valid_next   = 1'b1;
            word_start_next  = 1'b1;
        end else if (state_reg == SHIFT && !last_bit) begin
            data_stream_next = shift_reg[W-2];
            bit_valid_next   = 1'b1;
`ifdef SER_PARITY_EN
            if (bit_cnt_reg == CW'(W - 1))
                data_stream_next = parity_reg;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_stream_reg <= IDLE_BIT;
            bit_valid_reg   <= 1'b0;
            word_start_reg  <= 1'b0;
        end else begin
            data_stream_reg <= data_stream_next;
            bit_valid_reg   <= bit_valid_next;
            word_start_reg  <= word_start_next;
        end
    end

    assign bus.data_stream = data_stream_reg;
    assign bus.bit_valid   = bit_valid_reg;
    assign bus.word_start  = word_start_reg;
    assign bus.fifo_count  = count_reg;
endmodule

// File: tb/tb_seq_word_serializer.sv
// Directed bench for seq_word_serializer (W=8, DEPTH=4); adapts its expected
// stream lengths when SER_PARITY_EN is defined.
module tb_seq_word_serializer;
`ifdef SER_PARITY_EN
    localparam int NB  = 9;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 8;
    localparam bit PAR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    seq_word_serializer_if #(.W(8), .DEPTH(4)) bus ();

    seq_word_serializer #(.W(8), .DEPTH(4), .IDLE_BIT(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Stream monitor: reassembles words and counts valid bit periods.
    logic [8:0]  mon_bits = '0;
    int          mon_n    = 0;
    int          vb_cnt   = 0;
    logic [7:0]  rx_q[$];
    always @(negedge clock) begin
        if (bus.bit_valid) begin
            vb_cnt++;
            if (bus.word_start) begin
                mon_bits = '0;
                mon_n    = 0;
            end
            mon_bits = {mon_bits[7:0], bus.data_stream};
            mon_n++;
            if (mon_n == NB)
                rx_q.push_back(PAR ? mon_bits[8:1] : mon_bits[7:0]);
        end
    end

    // Downstream 0110 sequence detector fed by the serial stream.
    logic [3:0] det_hist;
    logic       det;
    always @(posedge clock) begin
        if (!reset) begin
            det_hist <= '0;
            det      <= 1'b0;
        end else begin
            det <= bus.bit_valid && ({det_hist[2:0], bus.data_stream} == 4'b0110);
            if (bus.bit_valid)
                det_hist <= {det_hist[2:0], bus.data_stream};
        end
    end

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_bits;
        logic       exp_par;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] words6[6];
        logic [17:0] s;
        int         idx, guard, max_cnt, base;
        logic       ready_before, saw_full_block;

        vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        vecs[1] = '{8'h07, 8'b0000_0111, 1'b1};
        vecs[2] = '{8'h03, 8'b0000_0011, 1'b0};
        vecs[3] = '{8'hFF, 8'b1111_1111, 1'b0};
        vecs[4] = '{8'h80, 8'b1000_0000, 1'b1};
        vecs[5] = '{8'h6D, 8'b0110_1101, 1'b1};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        repeat (3) step();
        check("rst_fifo_count", 32'(bus.fifo_count), 0);
        check("rst_bit_valid", 32'(bus.bit_valid), 0);
        check("rst_word_start", 32'(bus.word_start), 0);
        check("rst_data_stream", 32'(bus.data_stream), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 1);
        $display("reset sequence done");

        // Single words from idle, one table record each.
        for (int v = 0; v < 6; v++) begin
            bus.in_data  = vecs[v].word;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check("pre_bit_valid", 32'(bus.bit_valid), 0);
            check("pre_fifo_count", 32'(bus.fifo_count), 1);
            for (int k = 0; k < NB; k++) begin
                step();
                check("vec_data", 32'(bus.data_stream),
                      32'((k < 8) ? vecs[v].exp_bits[7-k] : vecs[v].exp_par));
                check("vec_bit_valid", 32'(bus.bit_valid), 1);
                check("vec_word_start", 32'(bus.word_start), (k == 0) ? 1 : 0);
            end
            step();
            check("post_bit_valid", 32'(bus.bit_valid), 0);
            check("post_data_idle", 32'(bus.data_stream), 0);
            check("post_fifo_count", 32'(bus.fifo_count), 0);
            $display("vector %0d word=%h serialized", v, vecs[v].word);
            repeat (2) step();
        end

        // Back-to-back words F0, 0F.
        if (PAR) s = {8'hF0, 1'b0, 8'h0F, 1'b0};
        else     s = {2'b00, 8'hF0, 8'h0F};
        bus.in_data  = 8'hF0;
        bus.in_valid = 1'b1;
        step();
        bus.in_data  = 8'h0F;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2*NB; k++) begin
            if (k > 0) step();
            check("b2b_data", 32'(bus.data_stream), 32'(s[2*NB-1-k]));
            check("b2b_bit_valid", 32'(bus.bit_valid), 1);
            check("b2b_word_start", 32'(bus.word_start), (k == 0 || k == NB) ? 1 : 0);
        end
        step();
        check("b2b_end_valid", 32'(bus.bit_valid), 0);
        $display("back-to-back F0/0F done");
        repeat (2) step();

        // Six words held on in_valid against a 4-deep FIFO.
        words6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.delete();
        idx = 0; guard = 0; max_cnt = 0; saw_full_block = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = words6[0];
        while (idx < 6 && guard < 200) begin
            ready_before = bus.in_ready;
            if (bus.fifo_count == 3'd4 && !bus.in_ready)
                saw_full_block = 1'b1;
            step();
            if (ready_before) begin
                idx++;
                if (idx < 6) bus.in_data = words6[idx];
            end
            if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
            guard++;
        end
        bus.in_valid = 1'b0;
        check("burst_accepted", 32'(idx), 6);
        check("burst_max_count", 32'(max_cnt), 4);
        check("burst_full_blocks", 32'(saw_full_block), 1);
        guard = 0;
        while (rx_q.size() < 6 && guard < 300) begin
            step();
            guard++;
        end
        check("burst_rx_count", 32'(rx_q.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size())
                check("burst_word", 32'(rx_q[i]), 32'(words6[i]));
        end
        $display("burst of 6 words done");
        repeat (NB + 2) step();

        // Reset during bit 3 of C3 with two words queued.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        step();
        bus.in_data  = 8'h55;
        step();
        bus.in_data  = 8'hAA;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("mid_data_bit3", 32'(bus.data_stream), 0);
        check("mid_fifo_count", 32'(bus.fifo_count), 2);
        reset = 1'b0;
        step();
        check("mrst_fifo_count", 32'(bus.fifo_count), 0);
        check("mrst_bit_valid", 32'(bus.bit_valid), 0);
        check("mrst_data_idle", 32'(bus.data_stream), 0);
        check("mrst_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b1;
        base = vb_cnt;
        repeat (30) step();
        check("mrst_no_residual", 32'(vb_cnt - base), 0);
        check("mrst_count_after", 32'(bus.fifo_count), 0);
        $display("mid-word reset done");

        // 06 into the 0110 detector.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h06;
        step();
        bus.in_valid = 1'b0;
        repeat (8) step();
        check("det_before", 32'(det), 0);
        step();
        check("det_fire", 32'(det), 1);
        step();
        check("det_after", 32'(det), 0);
        $display("detector chain done");
        repeat (NB + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_word_serializer.md
SEQ_WORD_SERIALIZER -- requirements
Module: seq_word_serializer

Interface
REQ-001 SHALL have parameter W, default 8, meaning word width in bits (W >= 2).
REQ-002 SHALL have parameter DEPTH, default 4, meaning input FIFO depth in words (power of 2, >= 2).
REQ-003 SHALL have parameter IDLE_BIT, default 1'b0, meaning the value driven on data_stream when no word is being shifted.
REQ-004 SHALL have port clock  input  1  single rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-low reset, sampled on rising clock edge.
REQ-006 SHALL have port in_data  input  W  parallel word to serialize.
REQ-007 SHALL have port in_valid  input  1  in_data holds a word.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port data_stream  output  1  registered serial bit, one per clock, for the downstream sequence detector.
REQ-010 SHALL have port bit_valid  output  1  data_stream carries a word (or parity) bit.
REQ-011 SHALL have port word_start  output  1  one-cycle pulse coincident with the first bit of each word.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of words held in the FIFO.

Function
REQ-013 SHALL accept a word on a rising edge where in_valid && in_ready.
REQ-014 SHALL drive in_ready = (fifo_count < DEPTH) && reset; never accept when full, no full-FIFO pass-through.
REQ-015 SHALL implement a two-state FSM: IDLE (no active word) and SHIFT (W or W+1 bit periods per word).
REQ-016 IDLE -> SHIFT at an edge where the FIFO is non-empty; the head word is popped into the shift register at that edge.
REQ-017 SHALL serialize MSB first: bit W-1 on data_stream during the first SHIFT cycle, bit 0 last.
REQ-018 Latency: word accepted at edge t into an empty FIFO while IDLE -> its MSB on data_stream after edge t+1.
REQ-019 On the edge completing the last bit period, a non-empty FIFO SHALL pop the next word with no gap; else -> IDLE.
REQ-020 Simultaneous push and pop in one edge SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-021 In IDLE, data_stream = IDLE_BIT and bit_valid = 0.
REQ-022 word_start SHALL be 1 only during the first bit period of a word; bit_valid 1 during every SHIFT bit period.
REQ-023 A bit counter of $clog2(W+1) bits SHALL track the bit position; no reliance on wrap-around.

Reset
REQ-024 With reset low at a rising edge: FIFO empty (fifo_count = 0, pointers 0), FSM IDLE, data_stream = IDLE_BIT, bit_valid = 0, word_start = 0.
REQ-025 Reset mid-word SHALL discard the partial word and all queued words; no residual bits after release.
REQ-026 in_ready SHALL be 0 while reset is low; first acceptance possible on the first edge with reset high.

Configuration
REQ-027 Macro SER_PARITY_EN: when defined, each word SHALL be followed by one even-parity bit (XOR of all W bits), bit period W+1, bit_valid = 1, word_start = 0.
REQ-028 Without SER_PARITY_EN, each word SHALL occupy exactly W bit periods and no parity logic is present.

Verification
REQ-029 W=8, parity off: push 8'hA5 at edge t into empty FIFO -> data_stream 1,0,1,0,0,1,0,1 after edges t+1..t+8, word_start only after t+1, then IDLE_BIT with bit_valid 0.
REQ-030 Push 8'hF0 then 8'h0F on consecutive edges -> 16 contiguous valid bits 11110000 00001111, word_start exactly twice, 8 cycles apart.
REQ-031 DEPTH=4, hold in_valid for 6 words during SHIFT -> fifo_count reaches 4, in_ready low; stalled word accepted on the pop edge, none lost or duplicated.
REQ-032 Assert reset low during bit 3 of 8'hC3 with 2 words queued -> next edge: fifo_count 0, bit_valid 0, data_stream IDLE_BIT; no further bits after release.
REQ-033 SER_PARITY_EN defined: push 8'h07 -> 9 bits 00000111 then 1; push 8'h03 -> parity bit 0; next word starts on the 10th period.
REQ-034 Chain to a 4-bit sequence detector (pattern 0110): push 8'h06 -> detector output asserts one cycle after the final bit 0 reaches it.
